// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode.
// Compacts masked fetch lanes into a ring and hands decode a prefix.
module inst_buffer #(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int DEPTH        = 16,
  parameter int PC_W         = 39
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [FETCH_WIDTH-1:0]          in_mask,
  input  logic [FETCH_WIDTH*32-1:0]       in_inst,
  input  logic [FETCH_WIDTH*PC_W-1:0]     in_pc,
  input  logic [FETCH_WIDTH-1:0]          in_exc,
  output logic                            in_ready,
  input  logic                            stall,
  input  logic                            flush,
  output logic [DECODE_WIDTH-1:0]         out_valid,
  output logic [DECODE_WIDTH*32-1:0]      out_inst,
  output logic [DECODE_WIDTH*PC_W-1:0]    out_pc,
  output logic [DECODE_WIDTH-1:0]         out_exc,
  output logic [$clog2(DEPTH):0]          count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     mem_inst [DEPTH];
  logic [PC_W-1:0] mem_pc   [DEPTH];
  logic            mem_exc  [DEPTH];

  logic [CW-1:0] head;
  logic [CW-1:0] tail;
  logic [CW-1:0] enq_n;
  logic [CW-1:0] enq_eff;
  logic [CW-1:0] deq_n;
  logic [CW-1:0] avail;
  logic [AW-1:0] offs [FETCH_WIDTH];
  logic          enq;
  logic          deq;

  // Running popcount gives each set lane its slot.
  always_comb begin
    enq_n = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      offs[i] = tail[AW-1:0] + enq_n[AW-1:0];
      enq_n   = enq_n + CW'(in_mask[i]);
    end
  end

  assign in_ready = !rst ||
    (count <= CW'(DEPTH - FETCH_WIDTH));
  assign enq = rst && in_valid &&
    in_ready && !flush;
  assign deq = rst && !stall && !flush;

  assign avail = (count > CW'(DECODE_WIDTH)) ?
    CW'(DECODE_WIDTH) : count;
  assign deq_n   = deq ? avail : '0;
  assign enq_eff = enq ? enq_n : '0;

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_out
    logic [AW-1:0] ridx;
    assign ridx = head[AW-1:0] + AW'(g);
    assign out_valid[g] = deq && (CW'(g) < avail);
    assign out_inst[g*32 +: 32]     = mem_inst[ridx];
    assign out_pc[g*PC_W +: PC_W]   = mem_pc[ridx];
    assign out_exc[g]               = mem_exc[ridx];
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + deq_n;
      tail  <= tail + enq_eff;
      count <= count + enq_eff - deq_n;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (in_mask[i]) begin
          mem_inst[offs[i]] <= in_inst[i*32 +: 32];
          mem_pc[offs[i]]   <= in_pc[i*PC_W +: PC_W];
          mem_exc[offs[i]]  <= in_exc[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer.
// Linear stimulus with immediate assertions.
module tb_inst_buffer;

  localparam int FW   = 4;
  localparam int DW   = 4;
  localparam int PC_W = 39;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [FW-1:0]     in_mask;
  logic [FW*32-1:0]  in_inst;
  logic [FW*PC_W-1:0] in_pc;
  logic [FW-1:0]     in_exc;
  logic              in_ready;
  logic              stall;
  logic              flush;
  logic [DW-1:0]     out_valid;
  logic [DW*32-1:0]  out_inst;
  logic [DW*PC_W-1:0] out_pc;
  logic [DW-1:0]     out_exc;
  logic [4:0]        count;

  int tests = 0;
  int fails = 0;
  logic [PC_W-1:0] q[$];

  inst_buffer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_mask(in_mask),
    .in_inst(in_inst), .in_pc(in_pc),
    .in_exc(in_exc), .in_ready(in_ready),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .out_exc(out_exc),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pkt(input logic [3:0] m,
                     input logic [PC_W-1:0] b,
                     input logic [3:0] e);
    logic [PC_W-1:0] p;
    in_valid = 1'b1;
    in_mask  = m;
    in_exc   = e;
    for (int i = 0; i < FW; i++) begin
      p = b + PC_W'(4 * i);
      in_pc[i*PC_W +: PC_W] = p;
      in_inst[i*32 +: 32] = 32'hC000_0000 ^ p[31:0];
    end
    #1;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    in_mask  = '0;
    #1;
  endtask

  function automatic logic [63:0] lpc(input int i);
    return 64'(out_pc[i*PC_W +: PC_W]);
  endfunction

  initial begin
    int av;
    logic [PC_W-1:0] b;
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_mask = '0;
    in_inst = '0; in_pc = '0; in_exc = '0;
    tick; tick;
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);
    rst = 1'b1;
    #1;
    chk("rst_count", 64'(count), 64'h0);

    // single packet, no bypass
    pkt(4'b1111, 39'h1000, 4'b0000);
    chk("nobypass", 64'(out_valid), 64'h0);
    tick; idle;
    chk("lat_cnt", 64'(count), 64'h4);
    chk("lat_valid", 64'(out_valid), 64'hF);
    for (int i = 0; i < 4; i++)
      chk("lat_pc", lpc(i), 64'h1000 + 64'(4 * i));
    chk("lat_inst", 64'(out_inst[2*32 +: 32]),
        64'hC000_1008);
    tick;
    chk("lat_drain", 64'(count), 64'h0);
    chk("lat_empty", 64'(out_valid), 64'h0);

    // compaction
    pkt(4'b1010, 39'h2000, 4'b1000);
    tick; idle;
    chk("cmp_valid", 64'(out_valid), 64'h3);
    chk("cmp_pc0", lpc(0), 64'h2004);
    chk("cmp_pc1", lpc(1), 64'h200C);
    chk("cmp_exc", 64'(out_exc[1:0]), 64'h2);
    chk("cmp_cnt", 64'(count), 64'h2);
    tick;
    chk("cmp_drain", 64'(count), 64'h0);

    // empty mask
    pkt(4'b0000, 39'h2100, 4'b0000);
    chk("m0_ready", 64'(in_ready), 64'h1);
    tick; idle;
    chk("m0_cnt", 64'(count), 64'h0);

    // fill under stall
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pkt(4'b1111, 39'h3000 + 39'(16 * k), 4'b0);
      chk("full_rdy", 64'(in_ready), 64'h1);
      chk("full_stv", 64'(out_valid), 64'h0);
      tick;
    end
    pkt(4'b1111, 39'h3040, 4'b0);
    chk("full_cnt", 64'(count), 64'd16);
    chk("full_nrdy", 64'(in_ready), 64'h0);
    tick; idle;
    chk("full_hold", 64'(count), 64'd16);
    stall = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("full_v", 64'(out_valid), 64'hF);
      for (int i = 0; i < 4; i++)
        chk("full_pc", lpc(i),
            64'h3000 + 64'(16 * k + 4 * i));
      tick;
    end
    chk("full_end", 64'(count), 64'h0);

    // wrap with continuous dequeue
    q.delete();
    for (int k = 0; k < 24; k++) begin
      b = 39'h4000 + 39'(16 * k);
      pkt(4'b0111, b, 4'b0);
      av = (q.size() > 4) ? 4 : q.size();
      chk("wrap_v", 64'(out_valid),
          64'((1 << av) - 1));
      for (int i = 0; i < av; i++)
        chk("wrap_pc", lpc(i), 64'(q[i]));
      for (int i = 0; i < av; i++)
        void'(q.pop_front());
      for (int i = 0; i < 3; i++)
        q.push_back(b + PC_W'(4 * i));
      tick;
      chk("wrap_cnt", 64'(count), 64'(q.size()));
      chk("wrap_max", 64'(count <= 5'd16), 64'h1);
    end
    idle;
    for (int n = 0; n < 8 && q.size() > 0; n++) begin
      av = (q.size() > 4) ? 4 : q.size();
      for (int i = 0; i < av; i++)
        chk("wrap_dpc", lpc(i), 64'(q[i]));
      for (int i = 0; i < av; i++)
        void'(q.pop_front());
      tick;
    end
    chk("wrap_end", 64'(count), 64'h0);

    // flush with concurrent enqueue
    stall = 1'b1;
    pkt(4'b1111, 39'h5000, 4'b0); tick;
    pkt(4'b1111, 39'h5010, 4'b0); tick;
    pkt(4'b0001, 39'h5020, 4'b0); tick;
    idle;
    chk("fl_cnt9", 64'(count), 64'd9);
    stall = 1'b0; flush = 1'b1;
    pkt(4'b1111, 39'h6000, 4'b0);
    chk("fl_valid", 64'(out_valid), 64'h0);
    tick;
    flush = 1'b0;
    idle;
    chk("fl_cnt", 64'(count), 64'h0);
    chk("fl_none", 64'(out_valid), 64'h0);
    pkt(4'b1111, 39'h7000, 4'b0);
    tick; idle;
    chk("fl_next", lpc(0), 64'h7000);
    chk("fl_ncnt", 64'(count), 64'h4);
    tick;

    // partial availability with enqueue
    stall = 1'b1;
    pkt(4'b0011, 39'h8000, 4'b0);
    tick;
    stall = 1'b0;
    pkt(4'b1111, 39'h8100, 4'b0);
    chk("pa_cnt2", 64'(count), 64'h2);
    chk("pa_valid", 64'(out_valid), 64'h3);
    chk("pa_pc0", lpc(0), 64'h8000);
    chk("pa_pc1", lpc(1), 64'h8004);
    tick; idle;
    chk("pa_cnt4", 64'(count), 64'h4);
    chk("pa_npc", lpc(0), 64'h8100);
    tick;
    chk("pa_end", 64'(count), 64'h0);

    // reset mid-operation
    stall = 1'b1;
    pkt(4'b1111, 39'h9000, 4'b0);
    tick; idle;
    chk("mr_cnt", 64'(count), 64'h4);
    rst = 1'b0;
    tick;
    chk("mr_valid", 64'(out_valid), 64'h0);
    rst = 1'b1;
    #1;
    chk("mr_zero", 64'(count), 64'h0);
    chk("mr_ready", 64'(in_ready), 64'h1);
    pkt(4'b1111, 39'h9100, 4'b0);
    tick; idle;
    chk("mr_first", 64'(count), 64'h4);
    stall = 1'b0;
    #1;
    chk("mr_pc", lpc(0), 64'h9100);
    tick;

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
